rf_sb_arbiter: RTL and testbench
================================

Name: rf_sb_arbiter

Overview:
Register-file controller between decode and the shared register file. Holds a per-register scoreboard of pending writes and stalls decode on RAW/WAW hazards. Arbitrates two writeback requesters (ALU, LSU) onto the single regfile write port with round-robin fairness. Drives the regfile read enables/addresses on behalf of decode.

Parameters:
NREGS, 32, number of architectural registers (x0 hardwired zero)
AW, 5, register address width, equals $clog2(NREGS)
XLEN, 32, data width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
id_valid_i  in  1  decode holds a valid instruction
id_rs_i  in  2xAW  source register addresses (index 0 = rs1, 1 = rs2)
id_rs_use_i  in  2  source operand actually used
id_rd_i  in  AW  destination register
id_rd_we_i  in  1  instruction writes rd
id_issue_i  in  1  instruction leaves decode this cycle (only legal when id_stall_o=0)
id_stall_o  out  1  hazard stall to decode
rf_raddr_o  out  2xAW  regfile read addresses
rf_ren_o  out  2  regfile read enables
alu_valid_i / lsu_valid_i  in  1  writeback request
alu_rd_i / lsu_rd_i  in  AW  writeback destination
alu_data_i / lsu_data_i  in  XLEN  writeback data
alu_ready_o / lsu_ready_o  out  1  request accepted this cycle
rf_waddr_o  out  AW  regfile write address (registered)
rf_wdata_o  out  XLEN  regfile write data (registered)
rf_wen_o  out  1  regfile write enable (registered)
sb_err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_ni=0 at clk edge): scoreboard all 0, rr pointer -> ALU preferred, rf_wen_o=0, rf_waddr_o=0, rf_wdata_o=0, sb_err_o=0. Combinational outputs settle from reset state. Reset mid-operation discards pending bits and any registered write.
- Reads: rf_raddr_o = id_rs_i; rf_ren_o[i] = id_valid_i & id_rs_use_i[i]. Pure combinational, no latency.
- Hazard: id_stall_o = id_valid_i & (RAW on any used rs with sb[rs]=1 | (id_rd_we_i & sb[id_rd_i]=1)). Register 0 never pending, never stalls.
- Scoreboard set: on id_issue_i & id_rd_we_i & id_rd_i!=0, sb[id_rd_i]<=1.
- Scoreboard clear: on the edge where rf_wen_o=1, sb[rf_waddr_o]<=0. Write is visible to reads the following cycle (regfile has no write-through).
- Set and clear of the same register in one cycle: set wins.
- Arbitration: grant is combinational. Only one requester valid gets ready. Both valid: pointer side wins, and the pointer flips to the other side after each two-way grant. Single-requester grants do not move the pointer. ready does not depend on any downstream backpressure; the write port always accepts one per cycle.
- Write path: 1-cycle latency. Granted rd/data are registered into rf_waddr_o/rf_wdata_o with rf_wen_o=1 next cycle. No grant -> rf_wen_o=0 and address/data hold.
- Writeback to rd=0: handshake completes, rf_wen_o stays 0.
- sb_err_o set (sticky until reset) on: an accepted writeback to a non-pending nonzero register; id_issue_i while id_stall_o=1; both requesters targeting the same nonzero rd in one cycle.

Decomposition:
- Shared package rf_pkg: AW/XLEN constants, wb_req_t struct {valid, rd, data}, rr_side_e enum {RR_ALU, RR_LSU}.
- Sub-module rr_arb2: 2-input round-robin arbiter with pointer register, reusable elsewhere. Scoreboard stays inline.

Test Plan:
- Reset then issue rd=5 (rd_we=1); next cycle decode uses rs1=5 -> id_stall_o=1. ALU writeback rd=5 data 0xDEADBEEF -> alu_ready_o=1; next cycle rf_wen_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; stall drops the cycle after.
- ALU (rd=3) and LSU (rd=4) both valid for 4 cycles, re-presenting after each grant -> grants alternate ALU, LSU, ALU, LSU. rf_waddr_o sequence 3, 4, 3, 4 with 1-cycle lag.
- Issue rd=0 -> no stall on a later use of rs=0. Writeback rd=0 -> ready=1, rf_wen_o=0, sb_err_o stays 0.
- Issue rd=7 in the same cycle rf_wen_o=1 clears rd=7 -> sb[7] remains 1 and a later use of rs=7 stalls.
- LSU writeback to non-pending rd=9 -> sb_err_o=1 and holds. Drive rst_ni=0 for one edge -> sb_err_o=0, rf_wen_o=0, all stalls clear.
- WAW: rd=2 pending, decode with rd=2 and rd_we=1 with no sources used -> id_stall_o=1 until the write completes.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types for the register-file controller: widths, writeback request, arbiter side.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_pkg;

    localparam int RF_NREGS = 32;
    localparam int RF_AW    = 5;
    localparam int RF_XLEN  = 32;

    // One writeback request as seen by the write-port arbiter.
    typedef struct packed {
        logic              valid;
        logic [RF_AW-1:0]  rd;
        logic [RF_XLEN-1:0] data;
    } wb_req_t;

    // Side currently holding round-robin priority.
    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rr_side_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; bit 0 is the ALU side, bit 1 the LSU side.
// Latency: grant is combinational from req; pointer updates on the clock edge.
// Backpressure: none; a lone requester is always granted, contention alternates.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rr_side_e ptr_q;
    rr_side_e ptr_d;

    // Priority pointer register, ALU preferred out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= RR_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Grant selection; only a two-way contest moves the pointer.
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (ptr_q == RR_ALU) begin
                    gnt   = 2'b01;
                    ptr_d = RR_LSU;
                end else begin
                    gnt   = 2'b10;
                    ptr_d = RR_ALU;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/rf_sb_arbiter.sv
// Regfile controller: pending-write scoreboard with RAW/WAW stall, read-port drive, 2:1 write arbitration.
// Latency: reads and stall are combinational; granted writeback appears on the write port 1 cycle later.
// Backpressure: decode is held by id_stall_o; writeback ready is the arbiter grant only (port takes one per cycle).
module rf_sb_arbiter
    import rf_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int AW    = RF_AW,
    parameter int XLEN  = RF_XLEN
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 id_valid_i,
    input  logic [1:0][AW-1:0]   id_rs_i,
    input  logic [1:0]           id_rs_use_i,
    input  logic [AW-1:0]        id_rd_i,
    input  logic                 id_rd_we_i,
    input  logic                 id_issue_i,
    output logic                 id_stall_o,
    output logic [1:0][AW-1:0]   rf_raddr_o,
    output logic [1:0]           rf_ren_o,
    input  logic                 alu_valid_i,
    input  logic [AW-1:0]        alu_rd_i,
    input  logic [XLEN-1:0]      alu_data_i,
    output logic                 alu_ready_o,
    input  logic                 lsu_valid_i,
    input  logic [AW-1:0]        lsu_rd_i,
    input  logic [XLEN-1:0]      lsu_data_i,
    output logic                 lsu_ready_o,
    output logic [AW-1:0]        rf_waddr_o,
    output logic [XLEN-1:0]      rf_wdata_o,
    output logic                 rf_wen_o,
    output logic                 sb_err_o
);

    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_d;
    logic [1:0]       raw_hit;
    logic             waw_hit;
    logic [1:0]       gnt;
    wb_req_t          alu_req;
    wb_req_t          lsu_req;
    wb_req_t          win_req;
    logic             win_wr;
    logic             err_set;

    assign rf_raddr_o = id_rs_i;
    assign rf_ren_o   = {2{id_valid_i}} & id_rs_use_i;

    // Hazard detect against pending writes; x0 is never marked so it never hits.
    always_comb begin
        raw_hit = 2'b00;
        for (int i = 0; i < 2; i++) begin
            raw_hit[i] = id_rs_use_i[i] & sb_q[id_rs_i[i]];
        end
        waw_hit = id_rd_we_i & sb_q[id_rd_i];
    end

    assign id_stall_o = id_valid_i & ((|raw_hit) | waw_hit);

    rr_arb2 u_arb (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .req   ({lsu_valid_i, alu_valid_i}),
        .gnt   (gnt)
    );

    assign alu_ready_o = gnt[0];
    assign lsu_ready_o = gnt[1];

    // Pick the granted request; a write to x0 completes the handshake but never hits the port.
    always_comb begin
        alu_req       = '{valid: alu_valid_i, rd: alu_rd_i, data: alu_data_i};
        lsu_req       = '{valid: lsu_valid_i, rd: lsu_rd_i, data: lsu_data_i};
        win_req       = gnt[1] ? lsu_req : alu_req;
        win_req.valid = |gnt;
        win_wr        = win_req.valid & (win_req.rd != '0);
    end

    // Protocol violations: stray writeback, issue under stall, colliding writebacks.
    always_comb begin
        err_set = (win_wr & ~sb_q[win_req.rd])
                | (id_issue_i & id_stall_o)
                | (alu_valid_i & lsu_valid_i & (alu_rd_i == lsu_rd_i) & (alu_rd_i != '0));
    end

    // Scoreboard next state: clear on the write-port edge, then issue sets (set wins).
    always_comb begin
        sb_d = sb_q;
        if (rf_wen_o) begin
            sb_d[rf_waddr_o] = 1'b0;
        end
        if (id_issue_i & id_rd_we_i & (id_rd_i != '0)) begin
            sb_d[id_rd_i] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // State: scoreboard, registered write port (address/data hold when idle), sticky error.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sb_q       <= '0;
            rf_wen_o   <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            sb_err_o   <= 1'b0;
        end else begin
            sb_q     <= sb_d;
            rf_wen_o <= win_wr;
            if (win_wr) begin
                rf_waddr_o <= win_req.rd;
                rf_wdata_o <= win_req.data;
            end
            sb_err_o <= sb_err_o | err_set;
        end
    end

endmodule

// File: tb/tb_rf_sb_arbiter.sv
// Bench for rf_sb_arbiter: directed scenarios plus random traffic against a set-based reference model.
// Latency: expected write-port contents are queued one cycle ahead and popped by the monitor.
// Backpressure: stimulus only issues when the model predicts no stall (except deliberate error cases).
module tb_rf_sb_arbiter;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int XLEN  = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                id_valid;
    logic [1:0][AW-1:0]  id_rs;
    logic [1:0]          id_rs_use;
    logic [AW-1:0]       id_rd;
    logic                id_rd_we;
    logic                id_issue;
    logic                id_stall;
    logic [1:0][AW-1:0]  rf_raddr;
    logic [1:0]          rf_ren;
    logic                alu_valid;
    logic [AW-1:0]       alu_rd;
    logic [XLEN-1:0]     alu_data;
    logic                alu_ready;
    logic                lsu_valid;
    logic [AW-1:0]       lsu_rd;
    logic [XLEN-1:0]     lsu_data;
    logic                lsu_ready;
    logic [AW-1:0]       rf_waddr;
    logic [XLEN-1:0]     rf_wdata;
    logic                rf_wen;
    logic                sb_err;

    always #5 clk = ~clk;

    rf_sb_arbiter #(.NREGS(NREGS), .AW(AW), .XLEN(XLEN)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .id_valid_i  (id_valid),
        .id_rs_i     (id_rs),
        .id_rs_use_i (id_rs_use),
        .id_rd_i     (id_rd),
        .id_rd_we_i  (id_rd_we),
        .id_issue_i  (id_issue),
        .id_stall_o  (id_stall),
        .rf_raddr_o  (rf_raddr),
        .rf_ren_o    (rf_ren),
        .alu_valid_i (alu_valid),
        .alu_rd_i    (alu_rd),
        .alu_data_i  (alu_data),
        .alu_ready_o (alu_ready),
        .lsu_valid_i (lsu_valid),
        .lsu_rd_i    (lsu_rd),
        .lsu_data_i  (lsu_data),
        .lsu_ready_o (lsu_ready),
        .rf_waddr_o  (rf_waddr),
        .rf_wdata_o  (rf_wdata),
        .rf_wen_o    (rf_wen),
        .sb_err_o    (sb_err)
    );

    typedef struct {
        bit            wen;
        bit            chk_ad;
        bit [AW-1:0]   addr;
        bit [XLEN-1:0] data;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    bit      mon_en  = 1'b0;

    // Reference model: set of registers with an outstanding write, whose turn it is on a
    // contest, the write currently on the port, and the sticky error flag.
    bit [NREGS-1:0] m_pend;
    bit             m_lsu_turn;
    bit             m_port_wen;
    bit [AW-1:0]    m_port_rd;
    bit             m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        bit hz;
        hz = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (id_rs_use[i] && m_pend[id_rs[i]]) hz = 1'b1;
        end
        if (id_rd_we && m_pend[id_rd]) hz = 1'b1;
        return id_valid && hz;
    endfunction

    task automatic idle();
        id_valid  = 1'b0;
        id_rs     = '0;
        id_rs_use = 2'b00;
        id_rd     = '0;
        id_rd_we  = 1'b0;
        id_issue  = 1'b0;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        lsu_valid = 1'b0;
        lsu_rd    = '0;
        lsu_data  = '0;
    endtask

    // One cycle: inputs already driven after a falling edge; check, advance model, wait.
    task automatic step();
        bit          stall;
        bit          both;
        bit          take_alu;
        bit          take_lsu;
        bit [AW-1:0] wrd;
        bit [XLEN-1:0] wdat;
        wr_exp_t     e;
        #1;
        stall = m_stall();
        both  = alu_valid && lsu_valid;
        if (both) begin
            take_alu = !m_lsu_turn;
            take_lsu = m_lsu_turn;
        end else begin
            take_alu = alu_valid;
            take_lsu = lsu_valid;
        end
        chk("id_stall", id_stall, stall);
        chk("rf_ren", rf_ren, {id_valid & id_rs_use[1], id_valid & id_rs_use[0]});
        chk("rf_raddr", rf_raddr, id_rs);
        chk("alu_ready", alu_ready, take_alu);
        chk("lsu_ready", lsu_ready, take_lsu);
        chk("sb_err", sb_err, m_err);

        wrd  = take_lsu ? lsu_rd : alu_rd;
        wdat = take_lsu ? lsu_data : alu_data;
        if ((take_alu || take_lsu) && wrd != 0 && !m_pend[wrd]) m_err = 1'b1;
        if (id_issue && stall) m_err = 1'b1;
        if (both && alu_rd == lsu_rd && alu_rd != 0) m_err = 1'b1;

        if (m_port_wen) m_pend[m_port_rd] = 1'b0;
        if (id_issue && id_rd_we && id_rd != 0) m_pend[id_rd] = 1'b1;
        if (both) m_lsu_turn = !m_lsu_turn;
        m_port_wen = (take_alu || take_lsu) && wrd != 0;
        m_port_rd  = wrd;

        e = '{m_port_wen, 1'b0, wrd, wdat};
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        wr_exp_t e;
        idle();
        rst_n      = 1'b0;
        mon_en     = 1'b1;
        m_pend     = '0;
        m_lsu_turn = 1'b0;
        m_port_wen = 1'b0;
        m_port_rd  = '0;
        m_err      = 1'b0;
        e = '{1'b0, 1'b1, '0, '0};
        exp_q.push_back(e);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue_rd(input int rd);
        idle();
        id_valid = 1'b1;
        id_rd    = AW'(rd);
        id_rd_we = 1'b1;
        id_issue = !m_stall();
        step();
    endtask

    // Monitor: the write port is compared after every rising edge against the queued prediction.
    always @(posedge clk) begin
        wr_exp_t e;
        if (mon_en) begin
            #1;
            if (exp_q.size() == 0) begin
                chk("rf_wen_unexpected", rf_wen, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("rf_wen", rf_wen, e.wen);
                if (e.wen || e.chk_ad) begin
                    chk("rf_waddr", rf_waddr, e.addr);
                    chk("rf_wdata", rf_wdata, e.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        idle();
        @(negedge clk);

        // RAW on rd=5, writeback, stall release.
        do_reset();
        issue_rd(5);
        idle();
        id_valid = 1'b1; id_rs[0] = 5'd5; id_rs_use = 2'b01;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        step();
        step();
        id_issue = 1'b1;
        step();

        // Contention between ALU rd=3 and LSU rd=4 alternates.
        do_reset();
        issue_rd(3);
        issue_rd(4);
        idle();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1000 + i;
            lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h2000 + i;
            step();
        end
        idle();
        step();

        // x0 destination: no scoreboard effect, writeback accepted but not written.
        do_reset();
        issue_rd(0);
        idle();
        id_valid = 1'b1; id_rs[0] = 5'd0; id_rs[1] = 5'd0; id_rs_use = 2'b11;
        step();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h12345678;
        step();
        idle();
        step();

        // Issue rd=7 on the same edge its previous write clears it: the new pending bit survives.
        do_reset();
        issue_rd(7);
        idle();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        step();
        idle();
        id_issue = 1'b1; id_rd = 5'd7; id_rd_we = 1'b1;
        step();
        idle();
        id_valid = 1'b1; id_rs[0] = 5'd7; id_rs_use = 2'b01;
        step();
        step();

        // Stray writeback raises the sticky error; reset clears everything.
        do_reset();
        idle();
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        step();
        idle();
        step();
        step();
        do_reset();
        id_valid = 1'b1; id_rs[0] = 5'd9; id_rs_use = 2'b01;
        step();

        // WAW on rd=2 with no sources used.
        do_reset();
        issue_rd(2);
        idle();
        id_valid = 1'b1; id_rd = 5'd2; id_rd_we = 1'b1;
        step();
        step();
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hCAFE0002;
        step();
        lsu_valid = 1'b0;
        step();
        step();
        id_issue = 1'b1;
        step();

        // Random legal traffic.
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            int pl[$];
            idle();
            for (int r = 1; r < NREGS; r++) if (m_pend[r]) pl.push_back(r);
            id_valid  = 1'($urandom_range(0, 1));
            id_rs[0]  = AW'($urandom_range(0, 7));
            id_rs[1]  = AW'($urandom_range(0, 7));
            id_rs_use = 2'($urandom_range(0, 3));
            id_rd     = AW'($urandom_range(0, 7));
            id_rd_we  = 1'($urandom_range(0, 1));
            id_issue  = !m_stall() && ($urandom_range(0, 1) == 1);
            if (pl.size() > 0) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd    = AW'(pl[$urandom_range(0, pl.size() - 1)]);
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_rd    = AW'(pl[$urandom_range(0, pl.size() - 1)]);
                if (alu_valid && lsu_valid && alu_rd == lsu_rd) lsu_valid = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                alu_valid = 1'b1;
                alu_rd    = '0;
            end
            alu_data = $urandom;
            lsu_data = $urandom;
            step();
        end
        idle();
        step();
        step();

        mon_en = 1'b0;
        chk("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
